// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer
// Purpose  : Byte FIFO fed by the core's UART write strobe, drained by an
//            8N1 serializer (LSB first) onto a registered, glitch-free tx line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffer #(
    parameter int CLK_PER_BIT = 434,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_wrreq,
    input  logic [7:0] uart_out,
    output logic       tx,
    output logic       full,
    output logic       busy,
    output logic       overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;

    localparam logic [TW-1:0]         c_BIT_LAST = TW'(CLK_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   c_DEPTH    = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [7:0]            r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic [2:0]            r_idx;
    logic [7:0]            r_shift;
    logic                  r_tx;

    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_bit_done;

    // Full is judged on the count held at the start of the cycle, so a write
    // that meets a full FIFO is dropped even if a pop frees a slot this cycle.
    assign w_full     = (r_count == c_DEPTH);
    assign w_push     = uart_wrreq && !w_full;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_bit_done = (r_timer == c_BIT_LAST);

    assign tx       = r_tx;
    assign full     = w_full;
    assign busy     = (r_state != S_IDLE) || (r_count != '0);
    assign overflow = r_overflow;

    // FIFO storage: written on every accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= uart_out;
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (uart_wrreq && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Serializer FSM; tx is loaded together with each state/bit transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_timer <= '0;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_idx   <= 3'd0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        if (r_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_tx  <= r_shift[r_idx + 3'd1];
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffer
// Purpose  : Self-checking bench for uart_tx_buffer against a queue-based
//            frame model (CLK_PER_BIT=4, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffer;

    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;

    logic       clk;
    logic       rst;
    logic       uart_wrreq;
    logic [7:0] uart_out;
    logic       tx;
    logic       full;
    logic       busy;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: pending bytes, the frame currently on the line and
    // how many cycles of it have elapsed since the pop edge.
    logic [7:0] q[$];
    logic       m_active;
    int         m_pos;
    logic [9:0] m_frame;
    logic       m_ovf;

    uart_tx_buffer #(
        .CLK_PER_BIT (CPB),
        .DEPTH_LOG2  (DL2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_wrreq (uart_wrreq),
        .uart_out   (uart_out),
        .tx         (tx),
        .full       (full),
        .busy       (busy),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic act, input logic exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, compare.
    task automatic tick(input logic wr, input logic [7:0] d, input logic r);
        int   pre;
        logic exp_tx;
        uart_wrreq = wr;
        uart_out   = d;
        rst        = r;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            pre = q.size();
            if (m_active) begin
                m_pos++;
                if (m_pos == 10 * CPB) m_active = 1'b0;
            end else if (pre > 0) begin
                m_frame  = {1'b1, q.pop_front(), 1'b0};
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (wr) begin
                if (pre == DEPTH) m_ovf = 1'b1;
                else              q.push_back(d);
            end
        end
        #1;
        exp_tx = m_active ? m_frame[m_pos / CPB] : 1'b1;
        chk("tx", tx, exp_tx);
        chk("busy", busy, m_active || (q.size() != 0));
        chk("full", full, q.size() == DEPTH);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        int   budget;
        logic seen_full;
        uart_wrreq = 1'b0;
        uart_out   = 8'h00;
        rst        = 1'b1;
        m_active   = 1'b0;
        m_pos      = 0;
        m_frame    = '1;
        m_ovf      = 1'b0;

        // Reset held for three cycles, then quiet line with no writes.
        repeat (3) tick(1'b0, 8'h00, 1'b1);
        idle(6);

        // Single byte 0xA5, then a random byte.
        tick(1'b1, 8'hA5, 1'b0);
        idle(10 * CPB + 5);
        tick(1'b1, 8'($urandom), 1'b0);
        idle(10 * CPB + 5);

        // Burst of four consecutive writes: full must never rise.
        seen_full = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            seen_full |= full;
        end
        chk("burst_no_full", seen_full, 1'b0);
        idle(4 * (10 * CPB + 1) + 5);

        // Overflow: six consecutive writes, the sixth is dropped.
        for (int i = 0; i < 6; i++) tick(1'b1, 8'h10 + 8'(i), 1'b0);
        chk("overflow_set", overflow, 1'b1);
        idle(5 * (10 * CPB + 1) + 5);
        chk("overflow_sticky", overflow, 1'b1);

        // Pointer wrap: twelve writes spaced 50 cycles apart.
        for (int i = 0; i < 12; i++) begin
            tick(1'b1, 8'(i), 1'b0);
            idle(49);
        end
        idle(10);

        // Random traffic, including writes into a full FIFO.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 5) == 0), 8'($urandom), 1'b0);
        end
        idle(DEPTH * (10 * CPB + 1) + 10);

        // Reset mid-frame during data bit 3 (frame slot 4).
        tick(1'b0, 8'h00, 1'b1);
        tick(1'b1, 8'hFF, 1'b0);
        budget = 0;
        while (!(m_active && (m_pos / CPB) == 4) && budget < 100) begin
            tick(1'b0, 8'h00, 1'b0);
            budget++;
        end
        chk("reached_data_bit3", budget < 100, 1'b1);
        tick(1'b0, 8'h00, 1'b1);
        chk("rst_tx_high", tx, 1'b1);
        chk("rst_busy_low", busy, 1'b0);
        idle(10 * CPB + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Transmit-side UART stage that sits directly downstream of the CPU core's memory-mapped UART port. It accepts bytes on the core's `uart_wrreq`/`uart_out` write strobe, buffers them in a small FIFO, and serializes them as 8N1 frames, LSB first, on a single `tx` line. Status outputs let software polling and the bench track buffer state and dropped writes.

## Interface

Parameters:
- `CLK_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16).

Ports:
- `clk`  input  1  system clock. This is the single clock.
- `rst`  input  1  synchronous reset, active-high.
- `uart_wrreq`  input  1  one-cycle write strobe from the core.
- `uart_out`  input  8  byte to transmit. Sampled when `uart_wrreq` is high.
- `tx`  output  1  serial line. Idles high.
- `full`  output  1  FIFO holds 2^DEPTH_LOG2 entries.
- `busy`  output  1  FIFO is non-empty or a frame is in progress.
- `overflow`  output  1  sticky flag: set when a write was dropped. Cleared only by `rst`.

## Operation

FIFO:
- Circular buffer with DEPTH_LOG2-bit read and write pointers and a (DEPTH_LOG2+1)-bit count. Pointers wrap modulo depth.
- Push: when `uart_wrreq` is high and `full` is low, the byte goes in at the write pointer, the pointer increments, and the count increments.
- Write while full: when `uart_wrreq` is high and `full` is high, the byte is dropped, `overflow` is set to 1, and FIFO state is unchanged.
- `full` is computed from the registered count at the start of the cycle. A write arriving while full is dropped even if a pop happens in the same cycle.
- Pop: happens only in IDLE with count > 0. The read-pointer entry is loaded into the shift register.
- Push and pop in the same cycle: the count is unchanged and both pointers advance.

Serializer FSM. It has a bit-timer counting 0..CLK_PER_BIT-1 and a 3-bit bit index.
- IDLE: `tx`=1. If count > 0, pop, clear the timer, go to START. Otherwise stay in IDLE.
- START: `tx`=0 for CLK_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: `tx` = shift[bit index] for CLK_PER_BIT cycles each. After index 7 completes, go to STOP.
- STOP: `tx`=1 for CLK_PER_BIT cycles, then go to IDLE.
- `tx` is driven from a register, so it is glitch-free.

Outputs:
- `busy` = (state ≠ IDLE) or (count ≠ 0). It is registered-consistent, with no combinational path from `uart_wrreq`.

Reset:
- Reset values: `tx`=1, `full`=0, `busy`=0, `overflow`=0, state=IDLE, pointers=0, count=0.
- Reset mid-frame aborts the frame. `tx` returns high on the cycle after the reset edge, and the FIFO contents are discarded.

## Timing

- Write at edge N (`uart_wrreq` high before edge N), FIFO empty, FSM idle:
  - count becomes 1 after edge N;
  - the pop occurs at edge N+1;
  - `tx` goes low after edge N+1.
- Frame length is exactly 10·CLK_PER_BIT cycles, from `tx` falling to the end of the stop bit.
- Back-to-back frames: after STOP, the FSM spends exactly one cycle in IDLE. The inter-frame gap is therefore 10·CLK_PER_BIT+1 cycles start-to-start.
- `full` and `busy` update on the edge after the push or pop that changes them.
- `overflow` rises on the edge that drops the write.
- Throughput: one byte per 10·CLK_PER_BIT+1 cycles. The core may write at most once per cycle.

## Test plan

Bench uses CLK_PER_BIT=4, DEPTH_LOG2=2 (depth 4).

1. Reset: hold `rst` for 3 cycles, then release. Required: `tx`=1, `full`=0, `busy`=0, `overflow`=0, and all stay at those values with no writes.
2. Single byte 0xA5 written at cycle 10. Required:
   - `tx` low during cycles 12–15;
   - data bits 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each;
   - stop high during cycles 48–51;
   - `busy` falls after cycle 51.
3. Burst of 0x01, 0x02, 0x03, 0x04 on consecutive cycles. Required:
   - `full` never asserts, because the first byte pops before the 4th write;
   - 4 frames go out in order;
   - start edges are 41 cycles apart.
4. Overflow: write 6 bytes 0x10–0x15 on consecutive cycles. Required:
   - 0x15 is dropped and `overflow`=1 from the following cycle;
   - exactly 0x10–0x14 are transmitted;
   - `overflow` stays 1 until `rst`.
5. Pointer wrap: 12 writes spaced 50 cycles apart, values 0x00–0x0B. Required: all received in order, covering 3 wraps of the pointers.
6. Reset mid-frame: write 0xFF, then assert `rst` during DATA bit 3. Required: `tx`=1 and `busy`=0 the cycle after the reset edge, and no further frame is sent.
